mac_lanes: RTL and testbench

Parametrised multiply-accumulate lane array for the Frodo matrix datapath, succeeding the fixed 4-lane Macs unit. It sits between matCtrl and the data RAMs. Each cycle it broadcasts one scalar `a` across LANES lanes and computes `c ± a·b[i]` modulo 2^LOG_Q, or accumulates into per-lane accumulators. A sideband tag is carried alongside for write-back addressing. The pipeline depth is configurable, and the pipeline has no backpressure.

---
 rtl/mac_lanes.sv | 145 ++++++++++++++
 tb/tb_mac_lanes.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mac_lanes.sv
// Broadcast multiply-accumulate lane array: result[i] = (addend[i] +/- a*b[i]) mod 2^LOG_Q,
// with the addend taken from c[i] or from a per-lane accumulator, over a fixed-latency pipeline.
module mac_lanes #(
  parameter int LANES       = 4,
  parameter int DW          = 16,
  parameter int LOG_Q       = 15,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  signal,
  input  logic                  clr,
  input  logic [DW-1:0]         a,
  input  logic [LANES*DW-1:0]   b,
  input  logic [LANES*DW-1:0]   c,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  valid,
  output logic [LANES*DW-1:0]   result,
  output logic [TAG_W-1:0]      tag_out
);

  // Handshake: en qualifies the inputs of the cycle it is high in; there is no ready,
  // the pipeline always advances, and valid pulses for exactly one cycle per accepted op,
  // PIPE_STAGES cycles after its en cycle.

  localparam int W = LANES * DW;
  localparam logic [DW-1:0] Q_MASK = DW'((64'd1 << LOG_Q) - 64'd1);

  logic [W-1:0] in_prod;

  always_comb begin
    in_prod = '0;
    for (int i = 0; i < LANES; i++) begin
      in_prod[i*DW +: DW] = a * b[i*DW +: DW];
    end
  end

  logic             fin_valid;
  logic             fin_mode;
  logic             fin_signal;
  logic [W-1:0]     fin_prod;
  logic [W-1:0]     fin_c;
  logic [TAG_W-1:0] fin_tag;

  if (PIPE_STAGES == 1) begin : g_direct
    assign fin_valid  = en;
    assign fin_mode   = mode;
    assign fin_signal = signal;
    assign fin_prod   = in_prod;
    assign fin_c      = c;
    assign fin_tag    = tag_in;
  end else begin : g_pipe
    localparam int NREG = PIPE_STAGES - 1;

    logic [NREG-1:0]  v_q;
    logic [NREG-1:0]  mode_q;
    logic [NREG-1:0]  sig_q;
    logic [W-1:0]     prod_q [NREG];
    logic [W-1:0]     c_q    [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q    <= '0;
        mode_q <= '0;
        sig_q  <= '0;
        for (int s = 0; s < NREG; s++) begin
          prod_q[s] <= '0;
          c_q[s]    <= '0;
          tag_q[s]  <= '0;
        end
      end else begin
        v_q[0]    <= en;
        mode_q[0] <= mode;
        sig_q[0]  <= signal;
        prod_q[0] <= in_prod;
        c_q[0]    <= c;
        tag_q[0]  <= tag_in;
        for (int s = 1; s < NREG; s++) begin
          v_q[s]    <= v_q[s-1];
          mode_q[s] <= mode_q[s-1];
          sig_q[s]  <= sig_q[s-1];
          prod_q[s] <= prod_q[s-1];
          c_q[s]    <= c_q[s-1];
          tag_q[s]  <= tag_q[s-1];
        end
      end
    end

    assign fin_valid  = v_q[NREG-1];
    assign fin_mode   = mode_q[NREG-1];
    assign fin_signal = sig_q[NREG-1];
    assign fin_prod   = prod_q[NREG-1];
    assign fin_c      = c_q[NREG-1];
    assign fin_tag    = tag_q[NREG-1];
  end

  logic [DW-1:0] acc [LANES];
  logic [W-1:0]  sum;

  // The add reads the live accumulator, so chained mode=1 ops see each other's results;
  // a concurrent clr forces the accumulator addend to zero.
  always_comb begin
    logic [DW-1:0] addend;
    logic [DW-1:0] raw;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      addend = '0;
      raw    = '0;
      if (fin_mode) addend = clr ? '0 : acc[i];
      else          addend = fin_c[i*DW +: DW];
      if (fin_signal) raw = addend - fin_prod[i*DW +: DW];
      else            raw = addend + fin_prod[i*DW +: DW];
      sum[i*DW +: DW] = raw & Q_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (fin_valid && fin_mode) begin
      for (int i = 0; i < LANES; i++) acc[i] <= sum[i*DW +: DW];
    end else if (clr) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      result  <= '0;
      tag_out <= '0;
    end else begin
      valid <= fin_valid;
      if (fin_valid) begin
        result  <= sum;
        tag_out <= fin_tag;
      end
    end
  end

endmodule

// File: tb/tb_mac_lanes.sv
// Directed bench for mac_lanes (LANES=4, DW=16, LOG_Q=15, PIPE_STAGES=2) with
// hand-computed expected results.
module tb_mac_lanes;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic        signal;
  logic        clr;
  logic [15:0] a;
  logic [63:0] b;
  logic [63:0] c;
  logic [11:0] tag_in;
  logic        valid;
  logic [63:0] result;
  logic [11:0] tag_out;

  int checks;
  int failures;

  mac_lanes #(
    .LANES(4), .DW(16), .LOG_Q(15), .PIPE_STAGES(2), .TAG_W(12)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .signal(signal), .clr(clr),
    .a(a), .b(b), .c(c), .tag_in(tag_in),
    .valid(valid), .result(result), .tag_out(tag_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver: called #1 after a rising edge; the op is sampled on the next edge
  task automatic op(input logic m, input logic s, input logic [15:0] av,
                    input logic [63:0] bv, input logic [63:0] cv, input logic [11:0] t);
    en = 1'b1; mode = m; signal = s; a = av; b = bv; c = cv; tag_in = t;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // after op(): not yet valid one half-cycle later, valid with the result one cycle on
  task automatic expect_retire(input string tag, input logic [63:0] exp_res,
                               input logic [11:0] exp_tag);
    @(negedge clk);
    check({tag, "_early"}, {63'd0, valid}, 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, {63'd0, valid}, 64'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_tag"}, {52'd0, tag_out}, {52'd0, exp_tag});
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; signal = 1'b0; clr = 1'b0;
    a = '0; b = '0; c = '0; tag_in = '0;

    // reset held 3 cycles with en toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      en = ~en; a = 16'd3; b = pack4(1, 2, 3, 4); c = pack4(5, 6, 7, 8); tag_in = 12'h0AA;
      @(negedge clk);
      check("rst_valid", {63'd0, valid}, 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_tag", {52'd0, tag_out}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;

    // multiply-add
    op(1'b0, 1'b0, 16'd3, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 12'h123);
    @(negedge clk);
    check("madd_early", {63'd0, valid}, 64'd0);
    @(negedge clk);
    check("madd_valid", {63'd0, valid}, 64'd1);
    check("madd_result", result, pack4(13, 26, 39, 52));
    check("madd_tag", {52'd0, tag_out}, 64'h123);
    @(negedge clk);
    check("madd_pulse", {63'd0, valid}, 64'd0);
    check("madd_hold", result, pack4(13, 26, 39, 52));
    check("madd_hold_tag", {52'd0, tag_out}, 64'h123);
    @(posedge clk); #1;

    // subtract with wrap and LOG_Q truncation of the addend
    op(1'b0, 1'b1, 16'd1, pack4(5, 3, 0, 0), pack4(2, 100, 7, 16'hFFFF), 12'h456);
    expect_retire("sub", pack4(16'h7FFD, 97, 7, 16'h7FFF), 12'h456);

    // accumulate chain after clr
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    en = 1'b1; mode = 1'b1; signal = 1'b0; a = 16'd2;
    b = pack4(7, 1, 16'h4000, 0); c = pack4(99, 99, 99, 99); tag_in = 12'h00C;
    @(posedge clk); #1;
    @(negedge clk);
    check("chain_early", {63'd0, valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("chain1_valid", {63'd0, valid}, 64'd1);
    check("chain1", result, pack4(14, 2, 0, 0));
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("chain2_valid", {63'd0, valid}, 64'd1);
    check("chain2", result, pack4(28, 4, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("chain3_valid", {63'd0, valid}, 64'd1);
    check("chain3", result, pack4(42, 6, 0, 0));
    @(posedge clk); #1;

    // product overflow: 0xFFFF*0xFFFF keeps low bits 0x0001
    op(1'b1, 1'b0, 16'hFFFF, pack4(16'hFFFF, 0, 0, 0), '0, 12'h0F0);
    expect_retire("ovf", pack4(43, 6, 0, 0), 12'h0F0);

    // clr while a mode=1 op sits in the final stage
    op(1'b1, 1'b0, 16'd1, pack4(5, 0, 0, 0), '0, 12'h111);
    clr = 1'b1;
    @(negedge clk);
    check("clr_early", {63'd0, valid}, 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_valid", {63'd0, valid}, 64'd1);
    check("clr_result", result, pack4(5, 0, 0, 0));
    @(posedge clk); #1;
    op(1'b1, 1'b0, 16'd1, pack4(0, 0, 0, 0), '0, 12'h112);
    expect_retire("clr_acc", pack4(5, 0, 0, 0), 12'h112);

    // reset mid-flight: op1 retires into acc, op2 is discarded
    en = 1'b1; mode = 1'b1; signal = 1'b0; a = 16'd1;
    b = pack4(9, 1, 0, 0); c = '0; tag_in = 12'h200;
    @(posedge clk); #1;
    tag_in = 12'h201;
    @(posedge clk); #1;
    en = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {63'd0, valid}, 64'd0);
    check("mid_rst_result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_valid", {63'd0, valid}, 64'd0);
    end
    check("mid_tag", {52'd0, tag_out}, 64'd0);
    @(posedge clk); #1;
    op(1'b1, 1'b0, 16'd1, pack4(3, 4, 0, 0), '0, 12'h2AB);
    expect_retire("post_rst", pack4(3, 4, 0, 0), 12'h2AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
